// File: rtl/result_accum_pkg.sv
// Shared types and default sizing for the result accumulator.
// State encoding plus the default DATA_WIDTH, SUM_WIDTH and COUNT.
package result_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_SUM_WIDTH  = 8;
  localparam int DEF_COUNT      = 4;

endpackage

// File: rtl/result_accum_if.sv
// Sample-in / sum-out handshake bundle for result_accum, with the synchronous clear.
// master = upstream/downstream side, slave = the accumulator.
interface result_accum_if
  import result_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SUM_WIDTH  = DEF_SUM_WIDTH
);
  logic                  clr;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [SUM_WIDTH-1:0]  out_sum;
  logic                  out_ovf;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/result_accum_sat_add.sv
// Combinational unsigned add of a zero-extended sample onto the running sum,
// clamped at all-ones; sat flags that the clamp engaged. Zero latency, no flow control.
module sat_add
  import result_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
  input  logic [SUM_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [SUM_WIDTH-1:0]  sum,
  output logic                  sat
);
  logic [SUM_WIDTH:0] full;

  always_comb begin
    full = {1'b0, a} + (SUM_WIDTH+1)'(b);
    sat  = full[SUM_WIDTH];
    sum  = sat ? '1 : full[SUM_WIDTH-1:0];
  end
endmodule

// File: rtl/result_accum.sv
// Sums COUNT accepted samples (saturating) and offers the total; out_valid one cycle after
// the last accept. in_ready drops while a sum waits for out_ready or while clr is high.
module result_accum
  import result_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SUM_WIDTH  = DEF_SUM_WIDTH,
  parameter int COUNT      = DEF_COUNT
) (
  input  logic           clk,
  input  logic           rst_n,
  result_accum_if.slave  bus
);
  localparam int          CW      = $clog2(COUNT + 1);
  localparam logic [CW-1:0] COUNT_C = CW'(COUNT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t               state_q, state_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [SUM_WIDTH-1:0] add_a;
  logic [SUM_WIDTH-1:0] add_sum;
  logic                 add_sat;
  logic [CW-1:0]        cnt_inc;

  // Adding onto zero in IDLE doubles as the zero-extended load of the first sample.
  assign add_a   = (state_q == ACCUM) ? sum_q : '0;
  assign cnt_inc = cnt_q + ONE_C;

  sat_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH)
  ) u_sat_add (
    .a   (add_a),
    .b   (bus.in_data),
    .sum (add_sum),
    .sat (add_sat)
  );

  assign bus.in_ready  = (state_q != EMIT) && !bus.clr;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      state_d = IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sum_d   = add_sum;
            cnt_d   = ONE_C;
            ovf_d   = add_sat;
            state_d = (ONE_C == COUNT_C) ? EMIT : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_d   = add_sum;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_q | add_sat;
            if (cnt_inc == COUNT_C) state_d = EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_result_accum.sv
// Directed bench for result_accum: per-cycle vector table on a COUNT=4 instance,
// plus hand sequences for saturation (COUNT=20), async reset mid-EMIT and COUNT=1.
module tb_result_accum;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  result_accum_if #(.DATA_WIDTH(4), .SUM_WIDTH(8)) ifa ();
  result_accum_if #(.DATA_WIDTH(4), .SUM_WIDTH(8)) ifb ();
  result_accum_if #(.DATA_WIDTH(4), .SUM_WIDTH(8)) ifc ();

  result_accum #(.DATA_WIDTH(4), .SUM_WIDTH(8), .COUNT(4))  u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  result_accum #(.DATA_WIDTH(4), .SUM_WIDTH(8), .COUNT(20)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  result_accum #(.DATA_WIDTH(4), .SUM_WIDTH(8), .COUNT(1))  u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct {
    logic       clr;
    logic       iv;
    logic [3:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_sum;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic iv, logic [3:0] d, logic ordy,
                              logic e_ir, logic e_ov, logic [7:0] e_sum, logic e_ovf);
    vec_t v;
    v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_sum = e_sum; v.e_ovf = e_ovf;
    return v;
  endfunction

  // Packed as {in_ready, out_valid, out_ovf, out_sum}.
  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got ir/ov/ovf/sum=%b/%b/%b/%h expected %b/%b/%b/%h", name,
               got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [10:0] pk(logic ir, logic ov, logic ovf, logic [7:0] s);
    return {ir, ov, ovf, s};
  endfunction

  task automatic drive_a(input logic clr, input logic iv, input logic [3:0] d, input logic ordy);
    ifa.clr = clr; ifa.in_valid = iv; ifa.in_data = d; ifa.out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 4'h0, 1'b0);
    ifb.clr = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = 4'h0; ifb.out_ready = 1'b0;
    ifc.clr = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = 4'h0; ifc.out_ready = 1'b0;

    // Samples 1..4 with immediate accept of the sum.
    vecs.push_back(mk(0, 1, 4'h1, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'h2, 1, 1, 0, 8'h01, 0));
    vecs.push_back(mk(0, 1, 4'h3, 1, 1, 0, 8'h03, 0));
    vecs.push_back(mk(0, 1, 4'h4, 1, 1, 0, 8'h06, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 8'h0A, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 0, 8'h00, 0));
    // Same samples, downstream stalls 3 cycles while upstream keeps offering.
    vecs.push_back(mk(0, 1, 4'h1, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'h2, 0, 1, 0, 8'h01, 0));
    vecs.push_back(mk(0, 1, 4'h3, 0, 1, 0, 8'h03, 0));
    vecs.push_back(mk(0, 1, 4'h4, 0, 1, 0, 8'h06, 0));
    vecs.push_back(mk(0, 1, 4'h5, 0, 0, 1, 8'h0A, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 1, 8'h0A, 0));
    vecs.push_back(mk(0, 1, 4'h5, 0, 0, 1, 8'h0A, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 8'h0A, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 8'h00, 0));
    // Two 7s, clear with a sample present, then four 5s with an idle gap.
    vecs.push_back(mk(0, 1, 4'h7, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'h7, 0, 1, 0, 8'h07, 0));
    vecs.push_back(mk(1, 1, 4'h7, 1, 0, 0, 8'h0E, 0));
    vecs.push_back(mk(0, 1, 4'h5, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 4'h9, 0, 1, 0, 8'h05, 0));
    vecs.push_back(mk(0, 1, 4'h5, 0, 1, 0, 8'h05, 0));
    vecs.push_back(mk(0, 1, 4'h5, 0, 1, 0, 8'h0A, 0));
    vecs.push_back(mk(0, 1, 4'h5, 0, 1, 0, 8'h0F, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 8'h14, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 8'h00, 0));

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("reset_a", pk(ifa.in_ready, ifa.out_valid, ifa.out_ovf, ifa.out_sum), pk(1, 0, 0, 8'h00));
    check("reset_b", pk(ifb.in_ready, ifb.out_valid, ifb.out_ovf, ifb.out_sum), pk(1, 0, 0, 8'h00));
    check("reset_c", pk(ifc.in_ready, ifc.out_valid, ifc.out_ovf, ifc.out_sum), pk(1, 0, 0, 8'h00));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_a(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d", i), pk(ifa.in_ready, ifa.out_valid, ifa.out_ovf, ifa.out_sum),
            pk(vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_ovf, vecs[i].e_sum));
      cyc();
    end

    // Async reset while a sum is pending.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 1'b1, 4'h2, 1'b0);
      cyc();
    end
    drive_a(1'b0, 1'b0, 4'h0, 1'b0);
    #1;
    check("rst_pre_emit", pk(ifa.in_ready, ifa.out_valid, ifa.out_ovf, ifa.out_sum), pk(0, 1, 0, 8'h08));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_emit", pk(ifa.in_ready, ifa.out_valid, ifa.out_ovf, ifa.out_sum), pk(1, 0, 0, 8'h00));
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    check("rst_release", pk(ifa.in_ready, ifa.out_valid, ifa.out_ovf, ifa.out_sum), pk(1, 0, 0, 8'h00));
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 1'b1, 4'h1, 1'b0);
      cyc();
    end
    drive_a(1'b0, 1'b0, 4'h0, 1'b1);
    #1;
    check("rst_after_sum", pk(ifa.in_ready, ifa.out_valid, ifa.out_ovf, ifa.out_sum), pk(0, 1, 0, 8'h04));
    cyc();
    check("rst_after_idle", pk(ifa.in_ready, ifa.out_valid, ifa.out_ovf, ifa.out_sum), pk(1, 0, 0, 8'h00));

    // Saturation: 17 x F lands exactly on FF, the 18th clamps.
    for (int i = 0; i < 20; i++) begin
      ifb.in_valid = 1'b1; ifb.in_data = 4'hF; ifb.out_ready = 1'b1;
      cyc();
      if (i == 16)
        check("sat_exact_ff", pk(ifb.in_ready, ifb.out_valid, ifb.out_ovf, ifb.out_sum), pk(1, 0, 0, 8'hFF));
      if (i == 17)
        check("sat_first_clamp", pk(ifb.in_ready, ifb.out_valid, ifb.out_ovf, ifb.out_sum), pk(1, 0, 1, 8'hFF));
    end
    ifb.in_valid = 1'b0;
    #1;
    check("sat_emit", pk(ifb.in_ready, ifb.out_valid, ifb.out_ovf, ifb.out_sum), pk(0, 1, 1, 8'hFF));
    cyc();
    check("sat_cleared", pk(ifb.in_ready, ifb.out_valid, ifb.out_ovf, ifb.out_sum), pk(1, 0, 0, 8'h00));

    // COUNT=1: every accept emits.
    ifc.in_valid = 1'b1; ifc.in_data = 4'h3; ifc.out_ready = 1'b1;
    cyc();
    ifc.in_valid = 1'b0; ifc.in_data = 4'h0;
    #1;
    check("c1_emit3", pk(ifc.in_ready, ifc.out_valid, ifc.out_ovf, ifc.out_sum), pk(0, 1, 0, 8'h03));
    cyc();
    ifc.in_valid = 1'b1; ifc.in_data = 4'h9;
    #1;
    check("c1_idle", pk(ifc.in_ready, ifc.out_valid, ifc.out_ovf, ifc.out_sum), pk(1, 0, 0, 8'h00));
    cyc();
    ifc.in_valid = 1'b0; ifc.in_data = 4'h0;
    #1;
    check("c1_emit9", pk(ifc.in_ready, ifc.out_valid, ifc.out_ovf, ifc.out_sum), pk(0, 1, 0, 8'h09));
    cyc();
    check("c1_done", pk(ifc.in_ready, ifc.out_valid, ifc.out_ovf, ifc.out_sum), pk(1, 0, 0, 8'h00));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/result_accum.md
RESULT_ACCUM -- requirements
Module: result_accum

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, setting the width of each consumed result sample.
REQ-002 The block SHALL have parameter SUM_WIDTH, default 8, setting the width of the accumulated sum.
REQ-003 The block SHALL have parameter COUNT, default 4, range 1..255, giving the number of samples per emitted sum.
REQ-004 The block SHALL have one clock: clk  input  1  rising-edge clock for all state.
REQ-005 The block SHALL have one reset: rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have clr  input  1  synchronous clear of the accumulation in progress.
REQ-007 The block SHALL have in_valid  input  1  upstream sample valid.
REQ-008 The block SHALL have in_data  input  DATA_WIDTH  upstream combinational result, treated as unsigned.
REQ-009 The block SHALL have in_ready  output  1  block can accept a sample this cycle.
REQ-010 The block SHALL have out_valid  output  1  accumulated sum is available.
REQ-011 The block SHALL have out_ready  input  1  downstream accepts the sum.
REQ-012 The block SHALL have out_sum  output  SUM_WIDTH  accumulated sum.
REQ-013 The block SHALL have out_ovf  output  1  saturation occurred during this accumulation.

Function
REQ-014 A sample SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and EMIT.
REQ-016 In IDLE, an accepted sample SHALL load sum=zero-extended in_data and cnt=1, then move to ACCUM, or to EMIT if COUNT=1.
REQ-017 In ACCUM, an accepted sample SHALL add zero-extended in_data to sum and increment cnt; the accept that makes cnt equal to COUNT SHALL move the FSM to EMIT.
REQ-018 out_valid SHALL assert in the cycle after the COUNT-th accept, and out_sum SHALL then include that final sample.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM and 0 in EMIT or whenever clr=1.
REQ-020 In EMIT, out_valid SHALL remain 1, and out_sum/out_ovf SHALL remain stable, until out_ready=1.
REQ-021 The EMIT handshake SHALL return the FSM to IDLE with sum=0, cnt=0 and out_ovf=0; in_ready SHALL be 1 in the following cycle.
REQ-022 Addition SHALL saturate at all-ones of SUM_WIDTH; any saturating add SHALL set out_ovf, which SHALL be sticky until the EMIT handshake.
REQ-023 clr=1 SHALL have priority over all other events, returning the block to IDLE with sum, cnt, out_valid and out_ovf cleared; a sample or out_ready presented in the same cycle SHALL be ignored.
REQ-024 Cycles with in_valid=0 SHALL leave sum, cnt and state unchanged.
REQ-025 The cnt width SHALL be $clog2(COUNT+1), and cnt SHALL never exceed COUNT.

Reset
REQ-026 Assertion of rst_n=0 SHALL asynchronously force state=IDLE, sum=0, cnt=0, out_valid=0 and out_ovf=0, which gives in_ready=1 once clr=0.
REQ-027 Reset asserted mid-ACCUM or mid-EMIT SHALL discard the partial or pending sum with no output handshake.
REQ-028 Deassertion of rst_n SHALL take effect on the next rising edge of clk, with no spurious out_valid.

Structure
REQ-029 The package result_accum_pkg SHALL hold the state enum (IDLE, ACCUM, EMIT) and the default DATA_WIDTH, SUM_WIDTH and COUNT constants.
REQ-030 The saturating add SHALL be a combinational sub-module sat_add, with inputs a[SUM_WIDTH] and b[DATA_WIDTH] and outputs sum[SUM_WIDTH] and sat.
REQ-031 All state SHALL be held in a single always_ff block with asynchronous reset, with next-state logic in always_comb.

Verification
REQ-032 Bench SHALL cover: COUNT=4, samples 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept, out_sum=8'h0A, out_ovf=0.
REQ-033 Bench SHALL cover: same samples with out_ready=0 for 3 cycles in EMIT -> out_sum held at 8'h0A, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-034 Bench SHALL cover: COUNT=20, 20 samples of 4'hF -> out_sum=8'hFF and out_ovf=1; out_ovf=0 after the handshake.
REQ-035 Bench SHALL cover: COUNT=4, 2 samples of 4'h7, then clr=1 with in_valid=1, then 4 samples of 4'h5 -> out_sum=8'h14.
REQ-036 Bench SHALL cover: rst_n=0 asserted mid-EMIT between clock edges -> out_valid=0 immediately; after release, 1,1,1,1 -> out_sum=8'h04.
REQ-037 Bench SHALL cover: COUNT=1 with in_valid alternating 1/0 and samples 3,9 -> two emits, out_sum=8'h03 then 8'h09.
